// File: rtl/tiny_oram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tiny_oram_port_arbiter
// Brief    : Round-robin front door merging NUM_PORTS client channels onto one
//            TinyORAM core; write bursts stay atomic, reads return in order.
//            Optional: ORAM_ARB_ADDR_PARTITION_EN confines each port to its
//            own slice of the address space.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_oram_port_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ORAMU       = 32,
    parameter int BECMD_WIDTH = 2,
    parameter int DM_WIDTH    = 8,
    parameter int FED_WIDTH   = 64,
    parameter int BLOCK_BEATS = 8,
    parameter int PEND_DEPTH  = 4
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_PORTS*BECMD_WIDTH-1:0] PortCmd,
    input  logic [NUM_PORTS*ORAMU-1:0]       PortPAddr,
    input  logic [NUM_PORTS*DM_WIDTH-1:0]    PortWMask,
    input  logic [NUM_PORTS-1:0]             PortCmdValid,
    output logic [NUM_PORTS-1:0]             PortCmdReady,
    input  logic [NUM_PORTS*FED_WIDTH-1:0]   PortDataIn,
    input  logic [NUM_PORTS-1:0]             PortDataInValid,
    output logic [NUM_PORTS-1:0]             PortDataInReady,
    output logic [FED_WIDTH-1:0]             PortDataOut,
    output logic [NUM_PORTS-1:0]             PortDataOutValid,
    input  logic [NUM_PORTS-1:0]             PortDataOutReady,
    output logic [BECMD_WIDTH-1:0]           Cmd,
    output logic [ORAMU-1:0]                 PAddr,
    output logic [DM_WIDTH-1:0]              WMask,
    output logic                             CmdValid,
    input  logic                             CmdReady,
    output logic [FED_WIDTH-1:0]             DataIn,
    output logic                             DataInValid,
    input  logic                             DataInReady,
    input  logic [FED_WIDTH-1:0]             DataOut,
    input  logic                             DataOutValid,
    output logic                             DataOutReady
);
    localparam int c_PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_BW = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int c_CW = $clog2(PEND_DEPTH + 1);
    localparam int c_FW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(BLOCK_BEATS - 1);
    localparam logic [c_CW-1:0] c_PEND_FULL = c_CW'(PEND_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CMD   = 2'd1;
    localparam logic [1:0] c_ST_WDATA = 2'd2;

    logic [1:0]      r_state;
    logic [c_PW-1:0] r_grant;
    logic [c_PW-1:0] r_rrPtr;
    logic [c_BW-1:0] r_beatCnt;
    logic [c_BW-1:0] r_retCnt;
    logic [c_CW-1:0] r_pendCount;
    logic [c_FW-1:0] r_wrPtr;
    logic [c_FW-1:0] r_rdPtr;
    logic [c_PW-1:0] r_fifo [PEND_DEPTH];

    logic                   w_anyValid;
    logic [c_PW-1:0]        w_pick;
    int                     w_idx;
    logic [BECMD_WIDTH-1:0] w_gCmd;
    logic [ORAMU-1:0]       w_gAddr;
    logic                   w_isRead;
    logic                   w_cmdValid;
    logic                   w_cmdHs;
    logic                   w_dataHs;
    logic                   w_push;
    logic                   w_empty;
    logic [c_PW-1:0]        w_head;
    logic                   w_dataOutReady;
    logic                   w_retHs;
    logic                   w_pop;

    // Cyclic search: first valid port at or after the round-robin pointer.
    always_comb begin
        w_anyValid = 1'b0;
        w_pick     = '0;
        w_idx      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = int'(r_rrPtr) + i;
            if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
            if (!w_anyValid && PortCmdValid[w_idx]) begin
                w_anyValid = 1'b1;
                w_pick     = c_PW'(w_idx);
            end
        end
    end

    assign w_gCmd   = PortCmd[r_grant*BECMD_WIDTH +: BECMD_WIDTH];
    assign w_gAddr  = PortPAddr[r_grant*ORAMU +: ORAMU];
    assign w_isRead = w_gCmd[1];
    assign w_empty  = (r_pendCount == '0);
    assign w_head   = r_fifo[r_rdPtr];

    // Full FIFO blocks only reads, judged on the registered count alone.
    assign w_cmdValid = (r_state == c_ST_CMD) && PortCmdValid[r_grant]
                        && !(w_isRead && (r_pendCount == c_PEND_FULL));
    assign w_cmdHs    = w_cmdValid && CmdReady;
    assign w_push     = w_cmdHs && w_isRead;
    assign w_dataHs   = (r_state == c_ST_WDATA) && PortDataInValid[r_grant] && DataInReady;

    assign w_dataOutReady = !w_empty && PortDataOutReady[w_head];
    assign w_retHs        = DataOutValid && w_dataOutReady;
    assign w_pop          = w_retHs && (r_retCnt == c_LAST_BEAT);

    assign PortDataOut  = DataOut;
    assign DataOutReady = w_dataOutReady;
    assign CmdValid     = w_cmdValid;

    always_comb begin
        Cmd              = '0;
        PAddr            = '0;
        WMask            = '0;
        PortCmdReady     = '0;
        DataIn           = '0;
        DataInValid      = 1'b0;
        PortDataInReady  = '0;
        PortDataOutValid = '0;
        if (r_state == c_ST_CMD) begin
            Cmd   = w_gCmd;
            WMask = PortWMask[r_grant*DM_WIDTH +: DM_WIDTH];
`ifdef ORAM_ARB_ADDR_PARTITION_EN
            PAddr = {r_grant, w_gAddr[ORAMU-c_PW-1:0]};
`else
            PAddr = w_gAddr;
`endif
            PortCmdReady[r_grant] = w_cmdHs;
        end
        if (r_state == c_ST_WDATA) begin
            DataIn                   = PortDataIn[r_grant*FED_WIDTH +: FED_WIDTH];
            DataInValid              = PortDataInValid[r_grant];
            PortDataInReady[r_grant] = DataInReady;
        end
        PortDataOutValid[w_head] = DataOutValid && !w_empty;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= '0;
            r_rrPtr     <= '0;
            r_beatCnt   <= '0;
            r_retCnt    <= '0;
            r_pendCount <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_anyValid) begin
                        r_grant <= w_pick;
                        r_state <= c_ST_CMD;
                    end
                end
                c_ST_CMD: begin
                    if (w_cmdHs) begin
                        r_rrPtr <= (int'(r_grant) == NUM_PORTS - 1) ? '0 : r_grant + 1'b1;
                        if (w_isRead) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_beatCnt <= '0;
                            r_state   <= c_ST_WDATA;
                        end
                    end
                end
                c_ST_WDATA: begin
                    if (w_dataHs) begin
                        if (r_beatCnt == c_LAST_BEAT) begin
                            r_beatCnt <= '0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_beatCnt <= r_beatCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_push) begin
                r_fifo[r_wrPtr] <= r_grant;
                r_wrPtr         <= (int'(r_wrPtr) == PEND_DEPTH - 1) ? '0 : r_wrPtr + 1'b1;
            end

            if (w_retHs) begin
                if (w_pop) begin
                    r_retCnt <= '0;
                    r_rdPtr  <= (int'(r_rdPtr) == PEND_DEPTH - 1) ? '0 : r_rdPtr + 1'b1;
                end else begin
                    r_retCnt <= r_retCnt + 1'b1;
                end
            end

            if (w_push && !w_pop)      r_pendCount <= r_pendCount + 1'b1;
            else if (w_pop && !w_push) r_pendCount <= r_pendCount - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tiny_oram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_oram_port_arbiter
// Brief    : Directed self-checking bench for tiny_oram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny_oram_port_arbiter;
    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    PortCmd;
    logic [127:0]  PortPAddr;
    logic [31:0]   PortWMask;
    logic [3:0]    PortCmdValid;
    logic [3:0]    PortCmdReady;
    logic [255:0]  PortDataIn;
    logic [3:0]    PortDataInValid;
    logic [3:0]    PortDataInReady;
    logic [63:0]   PortDataOut;
    logic [3:0]    PortDataOutValid;
    logic [3:0]    PortDataOutReady;
    logic [1:0]    Cmd;
    logic [31:0]   PAddr;
    logic [7:0]    WMask;
    logic          CmdValid;
    logic          CmdReady;
    logic [63:0]   DataIn;
    logic          DataInValid;
    logic          DataInReady;
    logic [63:0]   DataOut;
    logic          DataOutValid;
    logic          DataOutReady;

    int nAssert = 0;
    int nFail   = 0;

    tiny_oram_port_arbiter dut (
        .Clock(clk), .Reset(rst),
        .PortCmd(PortCmd), .PortPAddr(PortPAddr), .PortWMask(PortWMask),
        .PortCmdValid(PortCmdValid), .PortCmdReady(PortCmdReady),
        .PortDataIn(PortDataIn), .PortDataInValid(PortDataInValid),
        .PortDataInReady(PortDataInReady),
        .PortDataOut(PortDataOut), .PortDataOutValid(PortDataOutValid),
        .PortDataOutReady(PortDataOutReady),
        .Cmd(Cmd), .PAddr(PAddr), .WMask(WMask), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input int p, input logic [1:0] c, input logic [31:0] a, input logic [7:0] m);
        PortCmd[p*2 +: 2]    = c;
        PortPAddr[p*32 +: 32] = a;
        PortWMask[p*8 +: 8]  = m;
    endtask

    initial begin
        logic [31:0] expPart1;
        logic [31:0] expPart2;
        int p;
`ifdef ORAM_ARB_ADDR_PARTITION_EN
        expPart1 = 32'h8000_1234;
        expPart2 = 32'hC000_1234;
`else
        expPart1 = 32'h0000_1234;
        expPart2 = 32'h0000_1234;
`endif
        rst = 1'b1;
        PortCmd = '0; PortPAddr = '0; PortWMask = '0; PortCmdValid = '0;
        PortDataIn = '0; PortDataInValid = '0; PortDataOutReady = '1;
        CmdReady = 1'b1; DataInReady = 1'b1; DataOut = '0; DataOutValid = 1'b0;
        edge_(); edge_();

        // Reset state
        @(negedge clk);
        chk("rst_cmdvalid", CmdValid, 0);
        chk("rst_cmdready", PortCmdReady, 0);
        chk("rst_datainvalid", DataInValid, 0);
        chk("rst_dataoutready", DataOutReady, 0);
        chk("rst_paddr", PAddr, 0);
        chk("rst_portdov", PortDataOutValid, 0);
        edge_();
        rst = 1'b0;

        // A: four simultaneous reads, round-robin from port 0
        for (int i = 0; i < 4; i++) setCmd(i, 2'b10, 32'h100 + i, 8'h00);
        PortCmdValid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("A_idle_cv", CmdValid, 0);
            edge_();
            @(negedge clk);
            chk("A_cv", CmdValid, 1);
            chk("A_paddr", PAddr, 32'h100 + i);
            chk("A_cmdrdy", PortCmdReady, 64'd1 << i);
            edge_();
            PortCmdValid[i] = 1'b0;
        end
        @(negedge clk);
        chk("A_pend_peak", dut.r_pendCount, 4);
        edge_();
        DataOutValid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                DataOut = 64'hB000 + 64'(b * 16 + k);
                @(negedge clk);
                chk("A_ret_valid", PortDataOutValid, 64'd1 << b);
                chk("A_ret_ready", DataOutReady, 1);
                chk("A_ret_data", PortDataOut, 64'hB000 + 64'(b * 16 + k));
                edge_();
            end
        end
        DataOutValid = 1'b0;
        @(negedge clk);
        chk("A_pend_empty", dut.r_pendCount, 0);
        chk("A_empty_dor", DataOutReady, 0);
        edge_();

        // B: port 1 write burst is atomic against port 2's pending read
        setCmd(1, 2'b00, 32'h10, 8'hFF);
        setCmd(2, 2'b10, 32'h20, 8'h00);
        PortCmdValid = 4'b0110;
        @(negedge clk);
        chk("B_idle_cv", CmdValid, 0);
        edge_();
        @(negedge clk);
        chk("B_cv", CmdValid, 1);
        chk("B_cmd", Cmd, 2'b00);
        chk("B_paddr", PAddr, 32'h10);
        chk("B_wmask", WMask, 8'hFF);
        chk("B_cmdrdy", PortCmdReady, 4'b0010);
        edge_();
        PortCmdValid[1] = 1'b0;
        PortDataInValid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            PortDataIn[64 +: 64] = 64'hA0 + 64'(k);
            @(negedge clk);
            chk("B_div", DataInValid, 1);
            chk("B_din", DataIn, 64'hA0 + 64'(k));
            chk("B_dinrdy", PortDataInReady, 4'b0010);
            chk("B_nogrant_cv", CmdValid, 0);
            chk("B_nogrant_rdy", PortCmdReady, 0);
            edge_();
        end
        PortDataInValid = '0;
        @(negedge clk);
        chk("B_idle2_cv", CmdValid, 0);
        chk("B_idle2_div", DataInValid, 0);
        edge_();
        @(negedge clk);
        chk("B_p2_cv", CmdValid, 1);
        chk("B_p2_paddr", PAddr, 32'h20);
        chk("B_p2_rdy", PortCmdReady, 4'b0100);
        edge_();
        PortCmdValid[2] = 1'b0;
        @(negedge clk);
        chk("B_rrptr", dut.r_rrPtr, 3);
        chk("B_pend", dut.r_pendCount, 1);
        edge_();
        DataOutValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            DataOut = 64'hC0 + 64'(k);
            @(negedge clk);
            chk("B_ret_valid", PortDataOutValid, 4'b0100);
            edge_();
        end
        DataOutValid = 1'b0;

        // C: fifth read stalls on a full FIFO until the first block pops
        for (int i = 0; i < 4; i++) setCmd(i, 2'b10, 32'h300 + i, 8'h00);
        PortCmdValid = 4'hF;
        for (int j = 0; j < 4; j++) begin
            p = (j + 3) % 4;
            @(negedge clk);
            chk("C_idle_cv", CmdValid, 0);
            edge_();
            @(negedge clk);
            chk("C_cmdrdy", PortCmdReady, 64'd1 << p);
            edge_();
            if (p != 3) PortCmdValid[p] = 1'b0;
        end
        @(negedge clk);
        chk("C_idle5_cv", CmdValid, 0);
        edge_();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("C_full_cv", CmdValid, 0);
            chk("C_full_rdy", PortCmdReady, 0);
            chk("C_full_pend", dut.r_pendCount, 4);
            edge_();
        end
        DataOutValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            DataOut = 64'hE0 + 64'(k);
            @(negedge clk);
            chk("C_ret_valid", PortDataOutValid, 4'b1000);
            chk("C_stall_cv", CmdValid, 0);
            edge_();
        end
        DataOutValid = 1'b0;
        @(negedge clk);
        chk("C_after_cv", CmdValid, 1);
        chk("C_after_rdy", PortCmdReady, 4'b1000);
        chk("C_after_pend", dut.r_pendCount, 3);
        edge_();
        PortCmdValid = '0;
        @(negedge clk);
        chk("C_refill_pend", dut.r_pendCount, 4);
        edge_();

        // D: head port 0 back-pressures the return path
        PortDataOutReady = 4'b1110;
        DataOutValid = 1'b1;
        DataOut = 64'hD0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("D_dor_low", DataOutReady, 0);
            chk("D_pdov_head", PortDataOutValid, 4'b0001);
            edge_();
        end
        PortDataOutReady = 4'hF;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                DataOut = 64'hD00 + 64'(b * 16 + k);
                @(negedge clk);
                chk("D_ret_valid", PortDataOutValid, 64'd1 << b);
                chk("D_ret_cnt", dut.r_retCnt, k);
                chk("D_dor", DataOutReady, 1);
                edge_();
            end
        end
        DataOutValid = 1'b0;
        @(negedge clk);
        chk("D_pend_empty", dut.r_pendCount, 0);
        edge_();

        // E: reset aborts a write burst mid-way
        setCmd(1, 2'b00, 32'h40, 8'h0F);
        PortCmdValid = 4'b0010;
        @(negedge clk);
        edge_();
        @(negedge clk);
        chk("E_cmdrdy", PortCmdReady, 4'b0010);
        edge_();
        PortCmdValid = '0;
        PortDataInValid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            PortDataIn[64 +: 64] = 64'h50 + 64'(k);
            @(negedge clk);
            chk("E_din", DataIn, 64'h50 + 64'(k));
            edge_();
        end
        rst = 1'b1;
        PortDataIn[64 +: 64] = 64'h54;
        edge_();
        rst = 1'b0;
        @(negedge clk);
        chk("E_rst_cv", CmdValid, 0);
        chk("E_rst_div", DataInValid, 0);
        chk("E_rst_dinrdy", PortDataInReady, 0);
        chk("E_rst_din", DataIn, 0);
        chk("E_rst_dor", DataOutReady, 0);
        chk("E_rst_rrptr", dut.r_rrPtr, 0);
        chk("E_rst_pend", dut.r_pendCount, 0);
        edge_();
        PortDataInValid = '0;
        setCmd(2, 2'b10, 32'h0000_1234, 8'h00);
        PortCmdValid = 4'b0100;
        @(negedge clk);
        chk("E_idle_cv", CmdValid, 0);
        edge_();
        @(negedge clk);
        chk("E_p2_cv", CmdValid, 1);
        chk("E_p2_rdy", PortCmdReady, 4'b0100);
        chk("E_p2_paddr", PAddr, expPart1);
        edge_();
        setCmd(3, 2'b10, 32'h0000_1234, 8'h00);
        PortCmdValid = 4'b1000;
        @(negedge clk);
        edge_();
        @(negedge clk);
        chk("E_p3_rdy", PortCmdReady, 4'b1000);
        chk("E_p3_paddr", PAddr, expPart2);
        edge_();
        PortCmdValid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
`default_nettype wire
